// File: rtl/serial_uart_pkg.sv
// Shared definitions for the serial UART transmitter/receiver pair:
// FSM state encoding and 8N1 frame constants.
package serial_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_uart_fifo.sv
// Synchronous byte FIFO with registered occupancy count; pointers wrap
// naturally because DEPTH is a power of two.
module serial_uart_fifo
    import serial_uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == CW'(0));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointer and occupancy update; reset flushes the queue.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/serial_uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered byte input, clock-count bit divider,
// registered serial line that idles high. Frames chain with no idle gap.
module serial_uart_tx
    import serial_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_tx_state_t r_state;
    uart_tx_state_t w_state_nxt;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [CNT_W-1:0] w_clk_cnt_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_serial_out;
    logic             r_busy;
    logic             w_line_nxt;
    logic             w_bit_end;
    logic             w_pop;
    logic             w_push;
    logic [7:0]       w_fifo_data;
    logic             w_full;
    logic             w_empty;

    assign data_ready = !w_full && reset;
    assign w_push     = data_valid && data_ready;
    assign w_bit_end  = (r_clk_cnt == CNT_LAST);
    assign serial_out = r_serial_out;
    assign busy       = r_busy;

    serial_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk     (clk),
        .i_reset_n (reset),
        .i_push    (w_push),
        .i_data    (data_in),
        .i_pop     (w_pop),
        .o_data    (w_fifo_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (fifo_count)
    );

    // Next-state, divider, bit index and shift register update.
    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_pop         = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_fifo_data;
                    w_clk_cnt_nxt = CNT_W'(0);
                    w_state_nxt   = START;
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = CNT_W'(0);
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = CNT_W'(0);
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
                        w_bit_idx_nxt = 3'd0;
                        w_state_nxt   = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = CNT_W'(0);
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_data;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line level is derived from the upcoming state so the output can be registered.
    always_comb begin
        w_line_nxt = UART_STOP_BIT;
        case (w_state_nxt)
            START:   w_line_nxt = UART_START_BIT;
            DATA:    w_line_nxt = w_shift_nxt[0];
            default: w_line_nxt = UART_STOP_BIT;
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_clk_cnt    <= CNT_W'(0);
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'd0;
            r_serial_out <= UART_STOP_BIT;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clk_cnt    <= w_clk_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_serial_out <= w_line_nxt;
            r_busy       <= (w_state_nxt != IDLE);
        end
    end

endmodule

// File: doc/serial_uart_tx.md
# serial_uart_tx

Serial UART transmitter: the stage directly upstream of the `serial_UART` receiver. It accepts parallel bytes over a valid/ready handshake and buffers them in a small FIFO. Each byte is serialized as an 8N1 frame (start 0, 8 data bits LSB first, stop 1) on `serial_out`, which connects straight to the receiver's `serial_in`. Bit timing is set by a clock-count divider; at the default of one clock per bit it matches the receiver's one-bit-per-clock sampling.

## Interface
- `CLKS_PER_BIT`, default 1: clocks each bit is held on the line. Legal range ≥1.
- `FIFO_DEPTH`, default 4: byte FIFO depth. Must be a power of 2, ≥2.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `data_in`  in  8  byte to transmit.
- `data_valid`  in  1  `data_in` is valid this cycle.
- `data_ready`  out  1  FIFO can accept; a transfer occurs when `data_valid && data_ready` at a rising edge.
- `serial_out`  out  1  serial line, idle high, registered.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes buffered, not counting the byte being shifted.

## Operation
- Reset values: `serial_out`=1, `busy`=0, `fifo_count`=0, state IDLE, FIFO flushed. `data_ready`=0 while reset is asserted.
- `data_ready` = !full && reset. It is derived from the registered count only; there is no same-cycle pass-through when full.
- FSM states:
  - IDLE: line 1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: line 0 for CLKS_PER_BIT clocks, then go to DATA.
  - DATA: drive `shift[0]` for CLKS_PER_BIT clocks, then shift right and increment `bit_idx`. After bit 7 go to STOP.
  - STOP: line 1 for CLKS_PER_BIT clocks. On the last stop clock, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Divider `clk_cnt` counts 0..CLKS_PER_BIT-1 and wraps at the end of each bit. `bit_idx` is 3 bits wide.
- Push and pop in the same cycle leave `fifo_count` unchanged. Push into a full FIFO cannot occur because `data_ready` is low. Pop from an empty FIFO never occurs.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame: at the next edge the line returns to 1, the frame is abandoned and the FIFO is flushed. No partial-frame completion.
- `data_in` is sampled only on an accepted transfer. Its value while `data_valid`=0 is don't-care.

## Timing
- Byte accepted at edge N with FSM in IDLE: the start bit appears on `serial_out` after edge N+1.
- Frame length is exactly 10×CLKS_PER_BIT clocks. Data bit k occupies clocks (1+k)×CLKS_PER_BIT .. (2+k)×CLKS_PER_BIT−1 after frame start.
- `busy` rises with the start bit. It falls at the edge where the FSM returns to IDLE.
- Back-to-back bytes: the next start bit immediately follows the stop bit, giving 10×CLKS_PER_BIT clocks per byte sustained.
- A freed FIFO slot raises `data_ready` in the cycle after the pop.

## Structure
- Shared package `serial_uart_pkg` holds:
  - state enum `uart_tx_state_t` {IDLE, START, DATA, STOP};
  - constants `UART_DATA_BITS`=8, `UART_START_BIT`=1'b0, `UART_STOP_BIT`=1'b1.
- The receiver uses the same package.
- One sub-module: `serial_uart_fifo` (synchronous FIFO, parameter DEPTH, WIDTH=8, with push/pop/full/empty/count).
- The top level holds the FSM, divider and shift register.

## Test plan
- Single byte, CLKS_PER_BIT=1: push 8'hAB. `serial_out` reads 0,1,1,0,1,0,1,0,1,1 on consecutive clocks starting the cycle after acceptance. Looped into `serial_UART`, the receiver gives `data_out`=8'hAB with `valid`=1.
- Back-to-back: push 8'h55 then 8'h0F on consecutive cycles. Expect 20 contiguous frame clocks with no idle-high gap between stop and start. `busy` stays high for 20 cycles, then drops.
- Backpressure, FIFO_DEPTH=4: hold `data_valid`=1 with bytes 8'h01..8'h06. `data_ready` falls after the 5th accepted byte (4 buffered plus 1 shifting). The 6th byte is accepted the cycle after the first frame's stop bit ends. All six bytes are transmitted in order.
- Divider: CLKS_PER_BIT=3, push 8'h80. Each bit is held 3 clocks, the frame spans 30 clocks, and bit 7 (1) appears at clocks 24-26.
- Reset mid-frame: assert reset during data bit 3 of 8'hFF with 2 bytes queued. `serial_out`=1, `busy`=0 and `fifo_count`=0 after the next edge. No further frames are sent after release.
- Idle after reset: no pushes for 50 cycles. `serial_out` stays 1, `busy`=0, `data_ready`=1.
